// File: rtl/processador_pkg.sv
`default_nettype none
// ============================================================================
// processador_pkg : opcodes, ALU encoding, FSM states for processador_multiciclo
// Rev 1.0
// ============================================================================
package processador_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_HALT   = 3'd5;

  // True when both the opcode and its funct3 belong to the supported subset.
  function automatic logic legal_insn(input logic [31:0] ir);
    logic [2:0] f3;
    f3 = ir[14:12];
    case (ir[6:0])
      OPC_RTYPE:  legal_insn = (f3 == F3_ADD) || (f3 == F3_SLT) ||
                               (f3 == F3_OR)  || (f3 == F3_AND);
      OPC_OPIMM:  legal_insn = (f3 == F3_ADD);
      OPC_LOAD:   legal_insn = (f3 == F3_LW);
      OPC_STORE:  legal_insn = (f3 == F3_SW);
      OPC_BRANCH: legal_insn = (f3 == F3_BEQ) || (f3 == F3_BNE);
      OPC_JAL:    legal_insn = 1'b1;
      default:    legal_insn = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/banco_registradores_param.sv
`default_nettype none
// ============================================================================
// banco_registradores_param : NUM_REGS x 32 register bank, 2 async reads,
// 1 sync write, x0 and out-of-range addresses read as zero. Rev 1.0
// ============================================================================
module banco_registradores_param #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [1:NUM_REGS-1];

  always_ff @(posedge clk) begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (we_i && (waddr_i == 5'(i))) begin
        regs_q[i] <= wdata_i;
      end
    end
  end

  // Only real entries match, so x0 and addresses >= NUM_REGS fall through to 0.
  always_comb begin
    rdata1_o = 32'h0;
    rdata2_o = 32'h0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (raddr1_i == 5'(i)) rdata1_o = regs_q[i];
      if (raddr2_i == 5'(i)) rdata2_o = regs_q[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/processador_multiciclo.sv
`default_nettype none
// ============================================================================
// processador_multiciclo : multi-cycle RV32I-subset core, shared req/ready port.
// Optional macro PROCESSADOR_ILLEGAL_TRAP_EN: illegal instruction halts (trap).
// Rev 1.0
// ============================================================================
module processador_multiciclo
  import processador_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic [31:0] pc_out,
  output logic        trap
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] target_q, target_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] mdr_q, mdr_d;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        is_rtype, is_opimm, is_load, is_store, is_branch, is_jal, legal;
  logic [31:0] imm, alu_b, alu_res, pc_plus4, addr_sel;
  logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic [3:0]  alu_op;
  logic        rf_we, retire_w, br_taken;
  logic [1:0]  unused_addr_bits;

  assign opcode    = ir_q[6:0];
  assign rd        = ir_q[11:7];
  assign funct3    = ir_q[14:12];
  assign rs1       = ir_q[19:15];
  assign rs2       = ir_q[24:20];
  assign is_rtype  = (opcode == OPC_RTYPE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign legal     = legal_insn(ir_q);
  assign pc_plus4  = pc_q + 32'd4;
  assign br_taken  = (funct3 == F3_BNE) ? (a_q != b_q) : (a_q == b_q);

  always_comb begin
    imm = 32'h0;
    case (opcode)
      OPC_OPIMM, OPC_LOAD: imm = {{20{ir_q[31]}}, ir_q[31:20]};
      OPC_STORE:  imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OPC_BRANCH: imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OPC_JAL:    imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default:    imm = 32'h0;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    if (is_rtype) begin
      case (funct3)
        F3_ADD:  alu_op = ir_q[30] ? ALU_SUB : ALU_ADD;
        F3_SLT:  alu_op = ALU_SLT;
        F3_OR:   alu_op = ALU_OR;
        F3_AND:  alu_op = ALU_AND;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  assign alu_b = is_rtype ? b_q : imm;

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_res = a_q - alu_b;
      ALU_AND: alu_res = a_q & alu_b;
      ALU_OR:  alu_res = a_q | alu_b;
      ALU_SLT: alu_res = {31'h0, $signed(a_q) < $signed(alu_b)};
      default: alu_res = a_q + alu_b;
    endcase
  end

  banco_registradores_param #(
    .NUM_REGS (NUM_REGS)
  ) u_banco (
    .clk      (clk),
    .we_i     (rf_we & ~rst),
    .waddr_i  (rd),
    .wdata_i  (rf_wdata),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    target_d = target_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_wdata = aluout_q;
    retire_w = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d      = rf_rdata1;
        b_d      = rf_rdata2;
        target_d = pc_q + imm;
        state_d  = S_EXEC;
`ifdef PROCESSADOR_ILLEGAL_TRAP_EN
        if (!legal) state_d = S_HALT;
`endif
      end
      S_EXEC: begin
        if (!legal) begin
          pc_d     = pc_plus4;
          retire_w = 1'b1;
          state_d  = S_FETCH;
        end else if (is_branch) begin
          pc_d     = br_taken ? target_q : pc_plus4;
          retire_w = 1'b1;
          state_d  = S_FETCH;
        end else if (is_jal) begin
          rf_we    = 1'b1;
          rf_wdata = pc_plus4;
          pc_d     = target_q;
          retire_w = 1'b1;
          state_d  = S_FETCH;
        end else begin
          aluout_d = alu_res;
          state_d  = (is_load || is_store) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_store) begin
            pc_d     = pc_plus4;
            retire_w = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wdata = is_load ? mdr_q : aluout_q;
        pc_d     = pc_plus4;
        retire_w = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 32'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      target_q <= 32'h0;
      aluout_q <= 32'h0;
      mdr_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      target_q <= target_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
    end
  end

  // Port signals come straight from registers, so they hold during wait states;
  // gating with rst keeps a pending store from committing during reset.
  assign addr_sel         = (state_q == S_MEM) ? aluout_q : pc_q;
  assign unused_addr_bits = addr_sel[1:0];
  assign mem_req   = ~rst & ((state_q == S_FETCH) || (state_q == S_MEM));
  assign mem_we    = ~rst & (state_q == S_MEM) & is_store;
  assign mem_addr  = {addr_sel[31:2], 2'b00};
  assign mem_wdata = b_q;
  assign retire    = ~rst & retire_w;
  assign pc_out    = pc_q;

`ifdef PROCESSADOR_ILLEGAL_TRAP_EN
  assign trap = (state_q == S_HALT);
`else
  assign trap = 1'b0;
`endif

endmodule
`default_nettype wire
